instruction_fetch_unit: RTL and testbench

- Upstream neighbour of the instruction decoder.
- Holds the program counter and issues single-outstanding word fetches to instruction memory.
- Presents each fetched word with its PC in an output slot that the decode stage consumes under a valid/ready handshake.
- Accepts taken-branch redirects from execute. It computes the ARM-style target from the 24-bit branch offset and squashes any wrong-path fetch.

---
 rtl/instruction_fetch_unit.sv | 113 +++++++++++
 tb/tb_instruction_fetch_unit.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - single-outstanding instruction fetch with a one-entry output slot
// Branch redirects squash wrong-path fetches; a still-outstanding squashed request is drained in FLUSH.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc,
  output logic [31:0] link_addr,
  input  logic        decode_ready,
  input  logic        branch_taken,
  input  logic [31:0] branch_pc,
  input  logic [23:0] branch_offset
);

  typedef enum logic [1:0] {IDLE, FETCH, FULL, FLUSH} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] squash_q, squash_d;
  logic [31:0] instr_out_q, instr_out_d;
  logic [31:0] instr_pc_q, instr_pc_d;
  logic        instr_valid_q, instr_valid_d;
  logic [31:0] branch_target;
  logic [31:0] req_addr;

  assign branch_target = branch_pc + 32'd8 + {{6{branch_offset[23]}}, branch_offset, 2'b00};
  assign req_addr      = (state_q == FLUSH) ? squash_q : pc_q;

  assign imem_req    = (state_q == FETCH) || (state_q == FLUSH);
  assign imem_addr   = {req_addr[31:2], 2'b00};
  assign instr_valid = instr_valid_q;
  assign instr_out   = instr_out_q;
  assign instr_pc    = instr_pc_q;
  assign link_addr   = instr_pc_q + 32'd4;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    squash_d      = squash_q;
    instr_out_d   = instr_out_q;
    instr_pc_d    = instr_pc_q;
    instr_valid_d = instr_valid_q;

    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        if (imem_ready) begin
          instr_out_d   = imem_rdata;
          instr_pc_d    = pc_q;
          instr_valid_d = 1'b1;
          pc_d          = pc_q + 32'd4;
          state_d       = FULL;
        end
      end
      FULL: begin
        if (decode_ready) begin
          instr_valid_d = 1'b0;
          state_d       = FETCH;
        end
      end
      FLUSH: begin
        if (imem_ready) state_d = FETCH;
      end
      default: state_d = IDLE;
    endcase

    // Redirect overrides everything above; returned data in the same cycle is wrong-path.
    if (branch_taken) begin
      pc_d          = {branch_target[31:2], 2'b00};
      instr_valid_d = 1'b0;
      instr_out_d   = instr_out_q;
      instr_pc_d    = instr_pc_q;
      case (state_q)
        FETCH: begin
          if (imem_ready) begin
            state_d = FETCH;
          end else begin
            squash_d = pc_q;
            state_d  = FLUSH;
          end
        end
        FLUSH:   state_d = imem_ready ? FETCH : FLUSH;
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      pc_q          <= RESET_PC;
      squash_q      <= 32'h0;
      instr_out_q   <= 32'h0;
      instr_pc_q    <= 32'h0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      squash_q      <= squash_d;
      instr_out_q   <= instr_out_d;
      instr_pc_q    <= instr_pc_d;
      instr_valid_q <= instr_valid_d;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - scoreboard bench for instruction_fetch_unit
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic [31:0] link_addr;
  logic        decode_ready;
  logic        branch_taken;
  logic [31:0] branch_pc;
  logic [23:0] branch_offset;

  logic        w_req;
  logic [31:0] w_addr;
  logic        w_valid;
  logic [31:0] w_out, w_pc, w_link;
  logic [31:0] w_addrs[$];

  typedef struct {
    logic [31:0] pc;
    logic [31:0] word;
  } exp_t;
  exp_t sb_q[$];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'hE3A0_1000;
  endfunction

  assign imem_rdata = imem_ready ? mem_word(imem_addr) : 32'hDEAD_BEEF;

  instruction_fetch_unit u_dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .instr_valid(instr_valid), .instr_out(instr_out),
    .instr_pc(instr_pc), .link_addr(link_addr),
    .decode_ready(decode_ready), .branch_taken(branch_taken),
    .branch_pc(branch_pc), .branch_offset(branch_offset)
  );

  instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst_n(rst_n),
    .imem_req(w_req), .imem_addr(w_addr),
    .imem_ready(1'b1), .imem_rdata(mem_word(w_addr)),
    .instr_valid(w_valid), .instr_out(w_out),
    .instr_pc(w_pc), .link_addr(w_link),
    .decode_ready(1'b1), .branch_taken(1'b0),
    .branch_pc(32'h0), .branch_offset(24'h0)
  );

  always @(posedge clk) begin
    if (rst_n && w_req && w_addrs.size() < 2) w_addrs.push_back(w_addr);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic expect_word(input logic [31:0] pc);
    exp_t e;
    e.pc   = pc;
    e.word = mem_word(pc);
    sb_q.push_back(e);
  endtask

  // Pops the scoreboard whenever decode takes the slot, then advances one clock.
  task automatic cyc();
    exp_t e;
    if (instr_valid && decode_ready) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_word", instr_pc, 32'hFFFF_FFFF);
      end else begin
        e = sb_q.pop_front();
        chk("instr_pc", instr_pc, e.pc);
        chk("instr_out", instr_out, e.word);
        chk("link_addr", link_addr, e.pc + 32'd4);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; imem_ready = 1'b1; decode_ready = 1'b1;
    branch_taken = 1'b0; branch_pc = 32'h0; branch_offset = 24'h0;
    cyc(); cyc();
    chk("rst_req", {31'h0, imem_req}, 32'h0);
    chk("rst_valid", {31'h0, instr_valid}, 32'h0);
    chk("rst_out", instr_out, 32'h0);
    chk("rst_pc", instr_pc, 32'h0);

    // Sequential fetch with zero-wait memory: one instruction per two cycles
    rst_n = 1'b1;
    chk("idle_req", {31'h0, imem_req}, 32'h0);
    cyc();
    for (int i = 0; i < 3; i++) begin
      chk("seq_req", {31'h0, imem_req}, 32'h1);
      chk("seq_addr", imem_addr, 32'(i * 4));
      expect_word(32'(i * 4));
      cyc();
      chk("seq_full_req", {31'h0, imem_req}, 32'h0);
      chk("seq_valid", {31'h0, instr_valid}, 32'h1);
      cyc();
    end

    // Backpressure
    chk("bp_addr", imem_addr, 32'hC);
    decode_ready = 1'b0;
    expect_word(32'hC);
    cyc();
    for (int i = 0; i < 5; i++) begin
      chk("bp_pc", instr_pc, 32'hC);
      chk("bp_out", instr_out, mem_word(32'hC));
      chk("bp_req", {31'h0, imem_req}, 32'h0);
      cyc();
    end
    decode_ready = 1'b1;
    cyc();
    chk("bp_next_addr", imem_addr, 32'h10);
    chk("bp_next_req", {31'h0, imem_req}, 32'h1);

    // Negative-offset branch taken while FULL and decode consumes in the same cycle
    expect_word(32'h10);
    cyc();
    chk("nb_valid_pre", {31'h0, instr_valid}, 32'h1);
    branch_taken = 1'b1; branch_pc = 32'h10; branch_offset = 24'hFFFFFE;
    cyc();
    branch_taken = 1'b0;
    chk("nb_valid", {31'h0, instr_valid}, 32'h0);
    chk("nb_req", {31'h0, imem_req}, 32'h1);
    chk("nb_addr", imem_addr, 32'h10);

    // Squash: redirect while FETCH waits on memory
    imem_ready = 1'b0;
    branch_taken = 1'b1; branch_pc = 32'h20; branch_offset = 24'h000001;
    cyc();
    branch_taken = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("sq_req", {31'h0, imem_req}, 32'h1);
      chk("sq_hold_addr", imem_addr, 32'h10);
      chk("sq_valid", {31'h0, instr_valid}, 32'h0);
      cyc();
    end
    imem_ready = 1'b1;
    chk("sq_drain_addr", imem_addr, 32'h10);
    cyc();
    chk("sq_drop_valid", {31'h0, instr_valid}, 32'h0);
    chk("sq_target_addr", imem_addr, 32'h2C);
    expect_word(32'h2C);
    cyc();
    cyc();

    // Redirect in FETCH with data returning in the same cycle: data discarded
    chk("fd_addr", imem_addr, 32'h30);
    branch_taken = 1'b1; branch_pc = 32'h100; branch_offset = 24'h0;
    cyc();
    branch_taken = 1'b0;
    chk("fd_valid", {31'h0, instr_valid}, 32'h0);
    chk("fd_addr_new", imem_addr, 32'h108);
    chk("fd_req", {31'h0, imem_req}, 32'h1);

    // Asynchronous reset in the middle of an outstanding fetch
    imem_ready = 1'b0;
    cyc();
    chk("mr_req_pre", {31'h0, imem_req}, 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_req", {31'h0, imem_req}, 32'h0);
    chk("mr_valid", {31'h0, instr_valid}, 32'h0);
    cyc();
    rst_n = 1'b1; imem_ready = 1'b1;
    cyc();
    chk("mr_resume_addr", imem_addr, 32'h0);
    chk("mr_resume_req", {31'h0, imem_req}, 32'h1);
    expect_word(32'h0);
    cyc();
    cyc();

    chk("sb_left", sb_q.size(), 32'h0);
    chk("wrap_cnt", w_addrs.size(), 32'h2);
    if (w_addrs.size() >= 2) begin
      chk("wrap_first", w_addrs[0], 32'hFFFF_FFFC);
      chk("wrap_second", w_addrs[1], 32'h0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
